// File: rtl/nibble_serial_adder_ctrl.sv
// ============================================================================
// nibble_serial_adder_ctrl: wide add/sub that reuses one 4-bit ripple slice,
// processing one nibble per clock from the LSB to the MSB.  Rev 1.0
// ============================================================================
`default_nettype none

module fourbit_FA_str (
  output logic       Cout,
  output logic [3:0] S,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);
  logic [4:0] w_c;

  assign w_c[0] = Cin;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign S[g]     = A[g] ^ B[g] ^ w_c[g];
    assign w_c[g+1] = (A[g] & B[g]) | (w_c[g] & (A[g] ^ B[g]));
  end

  assign Cout = w_c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] S,
  output logic                 Cout,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    ar_q, br_q, s_q;
  logic            carry_q, busy_q, done_q, cout_q, ovf_q;

  logic [IW+1:0]   w_sh;
  logic [W-1:0]    w_a_shift, w_b_shift, w_mask, w_s_d;
  logic [3:0]      w_sum;
  logic            w_cout;

  // Slice operands come from the nibble selected by idx; the result nibble is
  // merged back into S at the same position.
  assign w_sh      = {idx_q, 2'b00};
  assign w_a_shift = ar_q >> w_sh;
  assign w_b_shift = br_q >> w_sh;
  assign w_mask    = W'(4'hF) << w_sh;
  assign w_s_d     = (s_q & ~w_mask) | (W'(w_sum) << w_sh);

  fourbit_FA_str u_slice (
    .Cout (w_cout),
    .S    (w_sum),
    .A    (w_a_shift[3:0]),
    .B    (w_b_shift[3:0]),
    .Cin  (carry_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ar_q    <= '0;
      br_q    <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: invert B once and seed the carry.
            ar_q    <= A;
            br_q    <= sub ? ~B : B;
            carry_q <= sub;
            idx_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q     <= w_s_d;
          carry_q <= w_cout;
          if (idx_q == C_LAST_IDX) begin
            cout_q  <= w_cout;
            ovf_q   <= (ar_q[W-1] == br_q[W-1]) && (w_sum[3] != ar_q[W-1]);
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ============================================================================
// tb_nibble_serial_adder_ctrl: table-driven and randomized checks of the
// nibble-serial add/sub sequencer against an integer-arithmetic model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder_ctrl;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] A, B;
  logic         busy, done, Cout, ovf;
  logic [W-1:0] S;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic res_t model(input logic op_sub, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    int ua, ub, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    if (op_sub) begin
      r.s  = W'(ua - ub);
      r.co = (ua >= ub);
      sr   = sa - sb;
    end else begin
      r.s  = W'(ua + ub);
      r.co = (ua + ub) >= (1 << W);
      sr   = sa + sb;
    end
    r.ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return r;
  endfunction

  // One operation from an idle DUT; checks latency, pulse width and result.
  task automatic run_op(input string tag, input logic op_sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input res_t exp);
    int busy_cnt = 0, done_cnt = 0, done_at = -1, k = 0;
    @(negedge clk);
    sub = op_sub; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; A = ~a; B = ~b; sub = ~op_sub;
    while (k < 20) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (!busy) break;
      @(posedge clk);
      k++;
    end
    chk({tag, " done_latency"}, done_at, NIB);
    chk({tag, " done_width"}, done_cnt, 1);
    chk({tag, " busy_cycles"}, busy_cnt, NIB + 1);
    chk({tag, " S"}, S, exp.s);
    chk({tag, " Cout"}, Cout, exp.co);
    chk({tag, " ovf"}, ovf, exp.ov);
  endtask

  initial begin
    vec_t vecs[6];
    res_t e;
    int   q_idx;
    res_t exp_q[$];
    logic [W-1:0] ra, rb;
    logic rsub;
    int saw_done;

    vecs[0] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset S", S, 0);
    chk("reset Cout", Cout, 0);
    chk("reset ovf", ovf, 0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      e.s = vecs[i].s; e.co = vecs[i].co; e.ov = vecs[i].ov;
      run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b, e);
    end

    // Randomized against the model.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rsub = 1'(($urandom));
      run_op($sformatf("rnd%0d", i), rsub, ra, rb, model(rsub, ra, rb));
    end

    // start held high, operands changing every cycle: accepts every NIB+2 edges.
    @(negedge clk);
    saw_done = 0;
    for (int c = 0; c < 5 * (NIB + 2); c++) begin
      ra = W'($urandom); rb = W'($urandom); rsub = 1'($urandom);
      A = ra; B = rb; sub = rsub; start = 1'b1;
      if (c % (NIB + 2) == 0) exp_q.push_back(model(rsub, ra, rb));
      @(negedge clk);
      chk($sformatf("stream done@%0d", c), done, (c % (NIB + 2)) == NIB);
      if (done) begin
        saw_done++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("stream S", S, e.s);
          chk("stream Cout", Cout, e.co);
          chk("stream ovf", ovf, e.ov);
        end
      end
    end
    chk("stream results", saw_done, 5);
    start = 1'b0;
    repeat (NIB + 3) @(negedge clk);

    // Async reset mid-operation at idx=2, with a carry pending.
    sub = 1'b0; A = 16'hFFFF; B = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst S", S, 0);
    chk("midrst Cout", Cout, 0);
    @(negedge clk);
    rst = 1'b0;
    q_idx = 0;
    for (int c = 0; c < NIB + 3; c++) begin
      @(negedge clk);
      if (done || busy) q_idx++;
    end
    chk("midrst no resume", q_idx, 0);
    e.s = 16'h0000; e.co = 1'b0; e.ov = 1'b0;
    run_op("post_rst", 1'b0, 16'h0000, 16'h0000, e);
    run_op("post_rst2", 1'b0, 16'h0F0F, 16'h0101, model(1'b0, 16'h0F0F, 16'h0101));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
